ripple_count_sampler: RTL

- Downstream consumer of the 4-bit T-flip-flop ripple down counter.
- The counter's outputs change asynchronously and pass through transient values while the ripple settles; this block synchronises them into the `clk` domain.
- It filters the transients, tracks zero-crossings (wraps) in an extended count, and flags skipped steps and compare matches.
- Its result is a clean, registered count that the synchronous logic can use directly.

---
 rtl/ripple_count_sampler.sv | 92 +++++++++
 1 files changed

// File: rtl/ripple_count_sampler.sv
// ripple_count_sampler: brings the asynchronous outputs of a 4-bit ripple
// down counter into the clk domain. It rejects ripple transients, counts
// zero crossings and flags skipped steps and compare matches.
module ripple_count_sampler #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned EXT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     cnt_in,
  input  logic                 clr,
  input  logic [WIDTH-1:0]     cmp_val,
  output logic [WIDTH-1:0]     count_out,
  output logic                 valid,
  output logic                 wrap_pulse,
  output logic [EXT_WIDTH-1:0] wrap_cnt,
  output logic                 match_pulse,
  output logic                 step_pulse_err,
  output logic                 err_flag
);

  localparam logic [WIDTH-1:0]     CNT_ONE = WIDTH'(1);
  localparam logic [EXT_WIDTH-1:0] EXT_ONE = EXT_WIDTH'(1);

  logic [WIDTH-1:0] s1, s2, s3;
  logic [2:0]       s_vld;
  logic [WIDTH-1:0] pred;
  logic             acc;
  logic             tracking;
  logic             is_wrap;
  logic             is_skip;

  // Sample pipeline: s1 synchroniser, s2/s3 filter pair. s_vld marks stages
  // holding real samples, so the zeros left by reset are never accepted as a
  // count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1    <= '0;
      s2    <= '0;
      s3    <= '0;
      s_vld <= '0;
    end else begin
      s1    <= cnt_in;
      s2    <= s1;
      s3    <= s2;
      s_vld <= {s_vld[1:0], 1'b1};
    end
  end

  // Accept a value seen on two consecutive samples; classify it against the
  // last accepted value.
  always_comb begin
    pred     = count_out - CNT_ONE;
    acc      = s_vld[2] && (s2 == s3) && (!valid || (s2 != count_out));
    tracking = acc && valid && !clr;
    is_wrap  = s2 > count_out;
    is_skip  = s2 != pred;
  end

  // Filtered count, wrap counter, sticky error and single-cycle pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_out      <= '0;
      valid          <= 1'b0;
      wrap_pulse     <= 1'b0;
      wrap_cnt       <= '0;
      match_pulse    <= 1'b0;
      step_pulse_err <= 1'b0;
      err_flag       <= 1'b0;
    end else begin
      wrap_pulse     <= tracking && is_wrap;
      step_pulse_err <= tracking && is_skip;
      match_pulse    <= acc && (s2 == cmp_val);

      if (acc) begin
        count_out <= s2;
        valid     <= 1'b1;
      end else if (clr) begin
        valid     <= 1'b0;
      end

      if (clr) begin
        wrap_cnt <= '0;
        err_flag <= 1'b0;
      end else if (tracking) begin
        if (is_wrap) wrap_cnt <= wrap_cnt + EXT_ONE;
        if (is_skip) err_flag <= 1'b1;
      end
    end
  end

endmodule
